bpp_counter: RTL and testbench



---
 rtl/bpp_pkg.sv | 21 ++
 rtl/bpp_counter64.sv | 36 +++
 rtl/bpp_counter.sv | 127 ++++++++++++
 tb/tb_bpp_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bpp_pkg.sv
// Shared constants for the bpp_counter peripheral: register offsets, bit positions and reset values.
package bpp_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_CYCLE_LO = 5'h04;
    localparam logic [4:0] OFF_CYCLE_HI = 5'h08;
    localparam logic [4:0] OFF_CMP_LO   = 5'h0C;
    localparam logic [4:0] OFF_CMP_HI   = 5'h10;
    localparam logic [4:0] OFF_STATUS   = 5'h14;
    localparam logic [4:0] OFF_SCRATCH  = 5'h18;
    localparam logic [4:0] OFF_ID       = 5'h1C;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_CLR_BIT     = 1;
    localparam int STATUS_MATCH_BIT = 0;

    localparam logic [31:0] CTRL_RST   = 32'h0000_0001;
    localparam logic [31:0] CMP_RST    = 32'hFFFF_FFFF;
    localparam logic [31:0] ID_DEFAULT = 32'h4250_5001;

endpackage

// File: rtl/bpp_counter64.sv
// 64-bit free-running cycle counter with enable, synchronous clear and a compare pulse.
module bpp_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [63:0] cmp_i,
    output logic [63:0] count_o,
    output logic        match_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Clear beats increment; the wrap from all-ones to zero is silent.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 64'd0;
        end else if (en_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign match_o = en_i && (count_q == cmp_i);

endmodule

// File: rtl/bpp_counter.sv
// Memory-mapped 64-bit cycle counter slave on the shared tri-state data bus.
// Optional BPP_SNAPSHOT_EN: a CYCLE_LO read latches the upper word so CYCLE_HI reads are tear-free.
module bpp_counter
    import bpp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0300,
    parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MADDR,
    inout  wire  [31:0] MDATA,
    input  logic        MEN,
    input  logic        MRW,
    inout  wire         MWAIT
);

    logic        sel;
    logic        wr;
    logic        rd;
    logic [4:0]  off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        unused_addr;

    logic        en_q,      en_d;
    logic [31:0] cmp_lo_q,  cmp_lo_d;
    logic [31:0] cmp_hi_q,  cmp_hi_d;
    logic        match_q,   match_d;
    logic [31:0] scratch_q, scratch_d;
    logic        clr;
    logic        match_pulse;
    logic [63:0] count;
    logic [31:0] cycle_hi;

    assign sel         = MEN && (MADDR[31:5] == BASE_ADDR[31:5]);
    assign wr          = sel && MRW;
    assign rd          = sel && !MRW;
    assign off         = {MADDR[4:2], 2'b00};
    assign wdata       = MDATA;
    assign unused_addr = ^MADDR[1:0];

    assign clr = wr && (off == OFF_CTRL) && wdata[CTRL_CLR_BIT];

    bpp_counter64 u_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (en_q),
        .clr_i   (clr),
        .cmp_i   ({cmp_hi_q, cmp_lo_q}),
        .count_o (count),
        .match_o (match_pulse)
    );

    always_comb begin
        en_d      = en_q;
        cmp_lo_d  = cmp_lo_q;
        cmp_hi_d  = cmp_hi_q;
        scratch_d = scratch_q;
        match_d   = match_q;
        if (wr) begin
            case (off)
                OFF_CTRL:    en_d      = wdata[CTRL_EN_BIT];
                OFF_CMP_LO:  cmp_lo_d  = wdata;
                OFF_CMP_HI:  cmp_hi_d  = wdata;
                OFF_SCRATCH: scratch_d = wdata;
                OFF_STATUS:  if (wdata[STATUS_MATCH_BIT]) match_d = 1'b0;
                default:     ;
            endcase
        end
        // A new match outranks a concurrent write-1-to-clear.
        if (match_pulse) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q      <= CTRL_RST[CTRL_EN_BIT];
            cmp_lo_q  <= CMP_RST;
            cmp_hi_q  <= CMP_RST;
            scratch_q <= 32'd0;
            match_q   <= 1'b0;
        end else begin
            en_q      <= en_d;
            cmp_lo_q  <= cmp_lo_d;
            cmp_hi_q  <= cmp_hi_d;
            scratch_q <= scratch_d;
            match_q   <= match_d;
        end
    end

`ifdef BPP_SNAPSHOT_EN
    logic [31:0] shadow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= 32'd0;
        end else if (rd && (off == OFF_CYCLE_LO)) begin
            shadow_q <= count[63:32];
        end
    end

    assign cycle_hi = shadow_q;
`else
    assign cycle_hi = count[63:32];
`endif

    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_CTRL:     rdata[CTRL_EN_BIT] = en_q;
            OFF_CYCLE_LO: rdata = count[31:0];
            OFF_CYCLE_HI: rdata = cycle_hi;
            OFF_CMP_LO:   rdata = cmp_lo_q;
            OFF_CMP_HI:   rdata = cmp_hi_q;
            OFF_STATUS:   rdata[STATUS_MATCH_BIT] = match_q;
            OFF_SCRATCH:  rdata = scratch_q;
            OFF_ID:       rdata = ID_VALUE;
            default:      rdata = 32'd0;
        endcase
    end

    assign MDATA = rd  ? rdata : 32'hzzzz_zzzz;
    assign MWAIT = sel ? 1'b0  : 1'bz;

endmodule

// File: tb/tb_bpp_counter.sv
// Directed bench for bpp_counter: register map, counter run/hold/clear, match, RO writes, wrap and reset abort.
module tb_bpp_counter;

    localparam logic [31:0] BASE = 32'h8000_0300;
    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_LO      = BASE + 32'h04;
    localparam logic [31:0] A_HI      = BASE + 32'h08;
    localparam logic [31:0] A_CMP_LO  = BASE + 32'h0C;
    localparam logic [31:0] A_CMP_HI  = BASE + 32'h10;
    localparam logic [31:0] A_STATUS  = BASE + 32'h14;
    localparam logic [31:0] A_SCRATCH = BASE + 32'h18;
    localparam logic [31:0] A_ID      = BASE + 32'h1C;

`ifdef BPP_SNAPSHOT_EN
    localparam logic [31:0] HI_AFTER_WRAP = 32'h0;
`else
    localparam logic [31:0] HI_AFTER_WRAP = 32'h1;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] MADDR;
    logic        MEN;
    logic        MRW;
    logic [31:0] drv;
    logic        drv_oe;
    wire  [31:0] MDATA;
    wire         MWAIT;

    logic [31:0] rd_data;
    logic        rd_wait;
    int          vectors;
    int          miscompares;

    assign MDATA = drv_oe ? drv : 32'hzzzz_zzzz;
    pullup (MWAIT);

    bpp_counter #(.BASE_ADDR(BASE), .ID_VALUE(32'h4250_5001)) dut (
        .clk   (clk),
        .rst   (rst),
        .MADDR (MADDR),
        .MDATA (MDATA),
        .MEN   (MEN),
        .MRW   (MRW),
        .MWAIT (MWAIT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MADDR = addr; MEN = 1'b1; MRW = 1'b1; drv = data; drv_oe = 1'b1;
    endtask

    task automatic bus_rd(input logic [31:0] addr);
        @(negedge clk);
        MADDR = addr; MEN = 1'b1; MRW = 1'b0; drv_oe = 1'b0;
        #2;
        rd_data = MDATA;
        rd_wait = MWAIT;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MEN = 1'b0; MRW = 1'b0; drv_oe = 1'b0;
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0; MADDR = 32'd0; MEN = 1'b0; MRW = 1'b0; drv = 32'd0; drv_oe = 1'b0;
        rd_data = 32'd0; rd_wait = 1'b0;

        // reads while reset is held return reset values
        idle(2);
        bus_rd(A_CTRL);   chk("rst_ctrl", rd_data, 32'h1);
        chk("rst_mwait_sel", {31'd0, rd_wait}, 32'h0);
        bus_rd(A_LO);     chk("rst_cycle_lo", rd_data, 32'h0);
        idle(1);
        rst = 1'b1;

        bus_rd(A_ID);     chk("id", rd_data, 32'h4250_5001);
        bus_rd(A_CMP_LO); chk("cmp_lo_rst", rd_data, 32'hFFFF_FFFF);
        bus_rd(A_STATUS); chk("status_rst", rd_data, 32'h0);
        bus_rd(32'h8000_0400); chk("unsel_mwait_z", {31'd0, rd_wait}, 32'h1);

        // clear+enable, run 10, stop: counter freezes at 11
        bus_wr(A_CTRL, 32'h3);
        idle(10);
        bus_wr(A_CTRL, 32'h0);
        bus_rd(A_LO);     chk("hold_a", rd_data, 32'd11);
        idle(5);
        bus_rd(A_LO);     chk("hold_b", rd_data, 32'd11);
        bus_rd(A_CTRL);   chk("ctrl_en0", rd_data, 32'h0);
        bus_wr(A_CTRL, 32'h1);
        bus_rd(A_LO);     chk("run_0", rd_data, 32'd11);
        bus_rd(A_LO);     chk("run_1", rd_data, 32'd12);
        bus_rd(A_LO);     chk("run_2", rd_data, 32'd13);

        // match at count 20 after clear
        bus_wr(A_CMP_LO, 32'd20);
        bus_wr(A_CMP_HI, 32'd0);
        bus_wr(A_CTRL, 32'h3);
        idle(20);
        bus_rd(A_STATUS); chk("match_before", rd_data, 32'h0);
        bus_rd(A_STATUS); chk("match_set", rd_data, 32'h1);
        bus_wr(A_STATUS, 32'h1);
        bus_rd(A_STATUS); chk("match_w1c", rd_data, 32'h0);

        // equal compare with EN=0 must not set MATCH
        bus_wr(A_CMP_LO, 32'd0);
        bus_wr(A_CTRL, 32'h2);
        idle(3);
        bus_rd(A_STATUS); chk("no_match_en0", rd_data, 32'h0);
        bus_wr(A_CMP_LO, 32'd5);

        // RO write is ignored, scratch is kept
        bus_wr(A_SCRATCH, 32'hDEAD_BEEF);
        bus_wr(A_LO, 32'h0000_1234);
        bus_rd(A_SCRATCH); chk("scratch", rd_data, 32'hDEAD_BEEF);
        bus_rd(A_LO);      chk("ro_write_ignored", rd_data, 32'h0);

        // low-word wrap into the upper word
        bus_wr(A_CTRL, 32'h1);
        @(negedge clk);
        force dut.u_cnt.count_q = 64'h0000_0000_FFFF_FFFF;
        MADDR = A_LO; MEN = 1'b1; MRW = 1'b0; drv_oe = 1'b0;
        #1;
        release dut.u_cnt.count_q;
        #1;
        chk("lo_preload", MDATA, 32'hFFFF_FFFF);
        bus_rd(A_HI);     chk("hi_after_wrap", rd_data, HI_AFTER_WRAP);
        bus_rd(A_LO);     chk("lo_after_wrap", rd_data, 32'h1);
        bus_rd(A_HI);     chk("hi_second", rd_data, 32'h1);

        // reset across a SCRATCH write edge aborts the write
        @(negedge clk);
        MADDR = A_SCRATCH; MEN = 1'b1; MRW = 1'b1; drv = 32'h0000_0055; drv_oe = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        MEN = 1'b0; drv_oe = 1'b0; rst = 1'b1;
        bus_rd(A_SCRATCH); chk("scratch_after_rst", rd_data, 32'h0);
        bus_rd(A_CTRL);    chk("ctrl_after_rst", rd_data, 32'h1);
        bus_rd(A_CMP_LO);  chk("cmp_after_rst", rd_data, 32'hFFFF_FFFF);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
